nibble_serial_adder_ctrl: RTL
=============================

Name: nibble_serial_adder_ctrl

Overview:
- Sequencer that adds two WIDTH-bit operands by time-multiplexing one 4-bit ripple-carry slice over WIDTH/4 clock cycles.
- Processes the least-significant nibble first and registers the carry between nibbles.
- Sits between a requester (valid/ready in) and a consumer (valid/ready out). It is the area-cheap alternative to a full-width adder in the arithmetic datapath.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and at least 4. Elaboration-time error otherwise.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  operand pair available.
- in_ready  out  1  controller can accept operands.
- a  in  WIDTH  operand A, sampled on the accept edge.
- b  in  WIDTH  operand B, sampled on the accept edge.
- sub  in  1  subtract request. Only honoured with SUBTRACT_EN; ignored otherwise.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- sum  out  WIDTH  result.
- co  out  1  carry out of the MSB. With SUBTRACT_EN and sub=1 it is inverted borrow: co=1 means no borrow.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Single clock domain: clk. Reset rst is synchronous, active-high. All state updates on the rising edge of clk.
- Derived constants:
  - NIB = WIDTH/4.
  - Index counter idx has width max(1, clog2(NIB)).
- States: IDLE, RUN, DONE.
- Reset:
  - state=IDLE, idx=0, carry=0.
  - sum=0, co=0, out_valid=0, busy=0.
  - in_ready=0 while rst is high; in_ready=1 on the first cycle after rst deasserts.
- Combinational outputs:
  - in_ready = (state==IDLE) && !rst.
  - out_valid = (state==DONE).
  - busy = (state!=IDLE).
- IDLE:
  - Accept occurs when in_valid && in_ready.
  - On accept: latch a and b into operand registers (b inverted if subtracting), carry = subtracting ? 1 : 0, idx=0, state -> RUN.
  - With no accept, hold all registers.
- RUN:
  - Every cycle, the slice adds nibble idx of A, nibble idx of B and carry.
  - The 4-bit result is written to sum[4*idx+3:4*idx]; carry is updated with the slice carry-out.
  - If idx==NIB-1: co = slice carry-out, state -> DONE. Otherwise idx increments.
  - in_valid is ignored and in_ready=0.
- DONE:
  - sum and co are held stable.
  - If out_ready=1: state -> IDLE, idx=0. sum and co keep their value; out_valid drops.
  - Otherwise hold indefinitely (back-pressure).
- Latency:
  - Accept on edge T gives out_valid high from cycle T+NIB+1.
  - Minimum initiation interval is NIB+2 cycles. There is no accept in the cycle of the output handshake, because in_ready is only high in IDLE.
- Boundary conditions:
  - WIDTH=4: NIB=1. RUN lasts exactly one cycle.
  - Arithmetic is modulo 2^WIDTH. The overflow indication is co only; there is no signed overflow flag.
  - rst asserted in any state, including mid-RUN: the in-flight operation is abandoned, with no partial out_valid. The reset values above take effect next cycle.
  - Operand inputs a, b and sub are don't-care outside the accept cycle.
  - During RUN, sum holds partially updated nibbles. sum is valid only while out_valid=1.

Optional Feature:
- Macro: SUBTRACT_EN.
- Defined: when sub=1 on the accept cycle, the result is A-B, computed as A + ~B + 1 (B inverted at latch, initial carry=1). co=0 indicates a borrow. The sub value is captured with the operands.
- Undefined: the sub port exists but is ignored. Result is always A+B and the initial carry is always 0. No inversion logic is synthesised.

Decomposition:
- Package nsa_pkg:
  - SLICE_W=4 constant.
  - State enum typedef {IDLE, RUN, DONE}.
  - Index-width function (clog2 wrapper with a minimum of 1).
- One sub-module: rca4_slice, a 4-bit ripple-carry adder with carry-in (a[3:0], b[3:0], ci, s[3:0], co), built from full-adder cells. It is instantiated once.
- The controller holds the FSM, idx counter, operand/carry registers and the result register.

Test Plan:
- WIDTH=16, a=0x1234, b=0x4321, out_ready=1 -> out_valid at accept+5 cycles, sum=0x5555, co=0, busy high for 5 cycles.
- a=0xFFFF, b=0x0001 -> carry ripples through all 4 nibbles: sum=0x0000, co=1.
- a=0x00FF, b=0x0001 with out_ready held 0 for 10 cycles -> out_valid stays 1, sum=0x0100 stable, in_ready=0 throughout. Raising out_ready gives out_valid=0 and in_ready=1 next cycle.
- Accept a=0xAAAA, b=0x5555; assert rst at accept+2 for one cycle -> out_valid never asserts, sum=0, in_ready=1 the cycle after rst drops. A new 0x0001+0x0002 then gives sum=0x0003.
- SUBTRACT_EN: sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, co=0. sub=1, a=0x0007, b=0x0005 -> sum=0x0002, co=1. Without the macro, the same stimulus gives sum=0x000C, co=0.
- WIDTH=4: a=0x9, b=0x8 -> out_valid at accept+2, sum=0x1, co=1. Back-to-back requests with in_valid held high are accepted every 3 cycles.

Source files
------------

// File: rtl/nsa_pkg.sv
// rtl/nsa_pkg.sv - shared constants, state type and index-width helper for the nibble-serial adder
package nsa_pkg;

    // Width of the single ripple-carry slice that is reused every cycle.
    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Counter width for NIB nibbles; never narrower than one bit so WIDTH=4 still has a register.
    function automatic int idx_width(input int nib);
        return (nib <= 1) ? 1 : $clog2(nib);
    endfunction

endpackage

// File: rtl/rca4_slice.sv
// rtl/rca4_slice.sv - 4-bit ripple-carry adder built from full-adder cells
//
// Ports:
//   a[3:0], b[3:0]  addend nibbles
//   ci              carry in
//   s[3:0]          sum nibble
//   co              carry out of bit 3
module rca4_slice
    import nsa_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               ci,
    output logic [SLICE_W-1:0] s,
    output logic               co
);

    logic [SLICE_W:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co = c[SLICE_W];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// rtl/nibble_serial_adder_ctrl.sv - WIDTH-bit adder sequencing one 4-bit slice over WIDTH/4 cycles
//
// Optional feature macro: SUBTRACT_EN (honour sub, computing A + ~B + 1).
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operand pair available
//   in_ready   controller can accept operands (IDLE and not in reset)
//   a, b       operands, sampled on the accept edge
//   sub        subtract request (ignored unless SUBTRACT_EN)
//   out_valid  result available (DONE)
//   out_ready  consumer takes the result
//   sum        result, valid while out_valid
//   co         carry out of the MSB (inverted borrow when subtracting)
//   busy       high in RUN or DONE
module nibble_serial_adder_ctrl
    import nsa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             busy
);

    localparam int NIB = WIDTH / SLICE_W;
    localparam int IW  = idx_width(NIB);

    if (((WIDTH % SLICE_W) != 0) || (WIDTH < SLICE_W)) begin : g_bad_width
        $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and at least 4");
    end

    state_e            state_q, state_d;
    logic [IW-1:0]     idx_q;
    logic              carry_q;
    logic [WIDTH-1:0]  a_q, b_q;
    logic [WIDTH-1:0]  sum_q;
    logic              co_q;

    logic              accept;
    logic              last_nib;
    logic [WIDTH-1:0]  b_load;
    logic              ci_load;
    logic [SLICE_W-1:0] slice_a, slice_b, slice_s;
    logic              slice_co;

`ifdef SUBTRACT_EN
    // Subtraction as A + ~B + 1: invert B once at load and seed the carry with 1.
    assign b_load  = sub ? ~b : b;
    assign ci_load = sub;
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign b_load     = b;
    assign ci_load    = 1'b0;
`endif

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign co        = co_q;

    assign accept   = in_valid && in_ready;
    assign last_nib = (idx_q == IW'(NIB - 1));

    assign slice_a = a_q[int'(idx_q)*SLICE_W +: SLICE_W];
    assign slice_b = b_q[int'(idx_q)*SLICE_W +: SLICE_W];

    rca4_slice u_slice (
        .a  (slice_a),
        .b  (slice_b),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = RUN;
            RUN:     if (last_nib)  state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            co_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q     <= a;
                        b_q     <= b_load;
                        carry_q <= ci_load;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    // sum is overwritten one nibble per cycle, LSB first.
                    sum_q[int'(idx_q)*SLICE_W +: SLICE_W] <= slice_s;
                    carry_q <= slice_co;
                    if (last_nib) begin
                        co_q <= slice_co;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        idx_q <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
